// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: state
// enumeration, major opcodes and datapath select values.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_ALU_WB   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL      = 4'd11,
      S_JALR     = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_RS1   = 2'd1;
   localparam logic [1:0] SRCA_OLDPC = 2'd2;

   localparam logic [1:0] SRCB_RS2   = 2'd0;
   localparam logic [1:0] SRCB_FOUR  = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;

   localparam logic [1:0] REGSRC_ALUOUT = 2'd0;
   localparam logic [1:0] REGSRC_MDR    = 2'd1;
   localparam logic [1:0] REGSRC_PC     = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

endpackage

// File: rtl/opcode_class_decoder.sv
// Maps the instruction opcode to the state that follows DECODE and flags
// opcodes the core does not implement.
module opcode_class_decoder
   import multicycle_pkg::*;
(
   input  logic [6:0] i_opcode,
   output state_t     o_next_state,
   output logic       o_illegal
);

   always_comb begin
      o_next_state = S_TRAP;
      o_illegal    = 1'b1;
      case (i_opcode)
         OP_LOAD, OP_STORE: begin o_next_state = S_MEM_ADDR; o_illegal = 1'b0; end
         OP_RTYPE:          begin o_next_state = S_EXEC_R;   o_illegal = 1'b0; end
         OP_ITYPE:          begin o_next_state = S_EXEC_I;   o_illegal = 1'b0; end
         OP_BRANCH:         begin o_next_state = S_BRANCH;   o_illegal = 1'b0; end
         OP_JAL:            begin o_next_state = S_JAL;      o_illegal = 1'b0; end
         OP_JALR:           begin o_next_state = S_JALR;     o_illegal = 1'b0; end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control sequencer for the multi-cycle RV32I core: steps the shared datapath
// through fetch/decode/execute/memory/writeback with a memory-ready handshake.
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] opCode,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       irWrite,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       regWrite,
   output logic [1:0] regSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       PCSource,
   output logic       instRetired,
   output logic       illegalInst,
   output logic [3:0] state
);

   state_t r_state;
   state_t w_next;
   state_t w_dec_next;
   logic   w_dec_illegal;

   opcode_class_decoder u_dec (
      .i_opcode     (opCode),
      .o_next_state (w_dec_next),
      .o_illegal    (w_dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   assign state = r_state;

   always_comb begin
      w_next      = r_state;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      irWrite     = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      regWrite    = 1'b0;
      regSrc      = REGSRC_ALUOUT;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RS2;
      ALUOp       = ALUOP_ADD;
      PCSource    = 1'b0;
      instRetired = 1'b0;
      illegalInst = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_FETCH;
         S_FETCH: begin
            memRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            if (memReady) begin
               irWrite = 1'b1;
               pcWrite = 1'b1;
               w_next  = S_DECODE;
            end
         end
         // PC+imm computed here lands in ALUOut for BRANCH/JAL
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            w_next  = w_dec_illegal ? S_TRAP : w_dec_next;
         end
         S_MEM_ADDR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            w_next  = opCode[5] ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            if (memReady) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            regWrite    = 1'b1;
            regSrc      = REGSRC_MDR;
            instRetired = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEM_WR: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            if (memReady) begin
               instRetired = 1'b1;
               w_next      = S_FETCH;
            end
         end
         S_EXEC_R: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_RTYPE;
            w_next  = S_ALU_WB;
         end
         S_EXEC_I: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ITYPE;
            w_next  = S_ALU_WB;
         end
         S_ALU_WB: begin
            regWrite    = 1'b1;
            instRetired = 1'b1;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = SRCA_RS1;
            ALUOp       = ALUOP_SUB;
            pcWriteCond = 1'b1;
            PCSource    = 1'b1;
            instRetired = 1'b1;
            w_next      = S_FETCH;
         end
         S_JAL: begin
            regWrite    = 1'b1;
            regSrc      = REGSRC_PC;
            pcWrite     = 1'b1;
            PCSource    = 1'b1;
            instRetired = 1'b1;
            w_next      = S_FETCH;
         end
         S_JALR: begin
            ALUSrcA     = SRCA_RS1;
            ALUSrcB     = SRCB_IMM;
            regWrite    = 1'b1;
            regSrc      = REGSRC_PC;
            pcWrite     = 1'b1;
            instRetired = 1'b1;
            w_next      = S_FETCH;
         end
         S_TRAP: illegalInst = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instructions are expanded into an expected
// per-cycle trace (state, inputs, outputs) and replayed against the DUT.
module tb_multicycle_controller;
   import multicycle_pkg::*;

   logic       clk = 1'b0;
   logic       reset, start, memReady;
   logic [6:0] opCode;
   logic       pcWrite, pcWriteCond, irWrite, iorD, memRead, memWrite, regWrite;
   logic [1:0] regSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic       PCSource, instRetired, illegalInst;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .start(start), .opCode(opCode), .memReady(memReady),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .irWrite(irWrite), .iorD(iorD),
      .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .regSrc(regSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .instRetired(instRetired), .illegalInst(illegalInst), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst, strt, rdy;
      logic [6:0] op;
      logic [3:0] st;
      logic       pcw, pcwc, irw, iord, mrd, mwr, rw;
      logic [1:0] rsrc, sa, sb, aop;
      logic       pcs, ret, ill;
   } step_t;

   step_t q[$];

   // Fresh step: inputs the current state must ignore are randomised.
   function automatic step_t base(input logic [3:0] st, input logic [6:0] op);
      step_t s = '0;
      s.st   = st;
      s.op   = op;
      s.rdy  = 1'($urandom);
      s.strt = 1'($urandom);
      return s;
   endfunction

   task automatic gen_idle(input logic go);
      step_t s = base(S_IDLE, 7'($urandom));
      s.strt = go;
      q.push_back(s);
   endtask

   task automatic gen_instr(input logic [6:0] op, input int unsigned wf,
                            input int unsigned wm, input int unsigned trap_cycles);
      step_t s;
      for (int unsigned i = 0; i <= wf; i++) begin
         s = base(S_FETCH, 7'($urandom));
         s.mrd = 1'b1; s.sb = 2'd1; s.rdy = (i == wf);
         if (i == wf) begin s.irw = 1'b1; s.pcw = 1'b1; end
         q.push_back(s);
      end
      s = base(S_DECODE, op); s.sa = 2'd2; s.sb = 2'd2;
      q.push_back(s);
      case (op)
         OP_LOAD, OP_STORE: begin
            s = base(S_MEM_ADDR, op); s.sa = 2'd1; s.sb = 2'd2;
            q.push_back(s);
            for (int unsigned i = 0; i <= wm; i++) begin
               s = base(op == OP_LOAD ? S_MEM_RD : S_MEM_WR, op);
               s.iord = 1'b1; s.rdy = (i == wm);
               if (op == OP_LOAD) s.mrd = 1'b1; else s.mwr = 1'b1;
               if (op == OP_STORE && i == wm) s.ret = 1'b1;
               q.push_back(s);
            end
            if (op == OP_LOAD) begin
               s = base(S_MEM_WB, op); s.rw = 1'b1; s.rsrc = 2'd1; s.ret = 1'b1;
               q.push_back(s);
            end
         end
         OP_RTYPE, OP_ITYPE: begin
            s = base(op == OP_RTYPE ? S_EXEC_R : S_EXEC_I, op);
            s.sa = 2'd1;
            s.sb = (op == OP_RTYPE) ? 2'd0 : 2'd2;
            s.aop = (op == OP_RTYPE) ? 2'b10 : 2'b11;
            q.push_back(s);
            s = base(S_ALU_WB, op); s.rw = 1'b1; s.ret = 1'b1;
            q.push_back(s);
         end
         OP_BRANCH: begin
            s = base(S_BRANCH, op); s.sa = 2'd1; s.aop = 2'b01;
            s.pcwc = 1'b1; s.pcs = 1'b1; s.ret = 1'b1;
            q.push_back(s);
         end
         OP_JAL: begin
            s = base(S_JAL, op); s.rw = 1'b1; s.rsrc = 2'd2;
            s.pcw = 1'b1; s.pcs = 1'b1; s.ret = 1'b1;
            q.push_back(s);
         end
         OP_JALR: begin
            s = base(S_JALR, op); s.sa = 2'd1; s.sb = 2'd2; s.rw = 1'b1;
            s.rsrc = 2'd2; s.pcw = 1'b1; s.ret = 1'b1;
            q.push_back(s);
         end
         default: begin
            for (int unsigned i = 0; i < trap_cycles; i++) begin
               s = base(S_TRAP, 7'($urandom)); s.ill = 1'b1;
               q.push_back(s);
            end
         end
      endcase
   endtask

   // Store whose write wait is cut short by reset on wait cycle cut_at.
   task automatic gen_store_reset(input int unsigned cut_at);
      step_t s;
      gen_instr(OP_STORE, 0, 0, 0);
      void'(q.pop_back());
      for (int unsigned i = 0; i <= cut_at; i++) begin
         s = base(S_MEM_WR, OP_STORE); s.iord = 1'b1; s.mwr = 1'b1; s.rdy = 1'b0;
         s.rst = (i == cut_at);
         q.push_back(s);
      end
   endtask

   task automatic run_queue();
      step_t s;
      logic [17:0] got, exp;
      int unsigned n = 0;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(negedge clk);
         reset = s.rst; start = s.strt; memReady = s.rdy; opCode = s.op;
         #1;
         got = {pcWrite, pcWriteCond, irWrite, iorD, memRead, memWrite, regWrite,
                regSrc, ALUSrcA, ALUSrcB, ALUOp, PCSource, instRetired, illegalInst};
         exp = {s.pcw, s.pcwc, s.irw, s.iord, s.mrd, s.mwr, s.rw,
                s.rsrc, s.sa, s.sb, s.aop, s.pcs, s.ret, s.ill};
         checks++;
         assert (state === s.st) else begin
            failures++;
            $error("FAIL state step=%0d got=%0d exp=%0d", n, state, s.st);
         end
         checks++;
         assert (got === exp) else begin
            failures++;
            $error("FAIL outputs step=%0d state=%0d got=%05h exp=%05h", n, s.st, got, exp);
         end
         n++;
      end
   endtask

   initial begin
      logic [6:0] legal [7];
      legal[0] = OP_LOAD;  legal[1] = OP_STORE; legal[2] = OP_RTYPE; legal[3] = OP_ITYPE;
      legal[4] = OP_BRANCH; legal[5] = OP_JAL; legal[6] = OP_JALR;

      reset = 1'b1; start = 1'b0; memReady = 1'b0; opCode = '0;
      repeat (2) @(posedge clk);

      // Directed: idle hold, R-type, load with 3 wait cycles, beq, jal
      gen_idle(1'b0); gen_idle(1'b0); gen_idle(1'b1);
      gen_instr(OP_RTYPE, 0, 0, 0);
      gen_instr(OP_LOAD, 0, 3, 0);
      gen_instr(OP_BRANCH, 0, 0, 0);
      gen_instr(OP_JAL, 0, 0, 0);
      gen_instr(OP_JALR, 1, 0, 0);
      gen_instr(OP_ITYPE, 2, 0, 0);
      gen_instr(OP_STORE, 0, 2, 0);
      run_queue();

      // Randomised instruction stream with random memory waits
      for (int i = 0; i < 60; i++)
         gen_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3), 0);
      run_queue();

      // Reset during a store wait, then restart
      gen_store_reset(1);
      gen_idle(1'b0); gen_idle(1'b1);
      gen_instr(OP_LOAD, 0, 0, 0);
      run_queue();

      // Illegal opcode traps until reset
      gen_instr(7'b1111111, 0, 0, 10);
      begin
         step_t s = base(S_TRAP, 7'($urandom)); s.ill = 1'b1; s.rst = 1'b1;
         q.push_back(s);
      end
      gen_idle(1'b0); gen_idle(1'b1);
      gen_instr(OP_RTYPE, 0, 0, 0);
      gen_instr(7'b0000000, 1, 0, 3);
      run_queue();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control sequencer for the multi-cycle variant of the RV32I core. It drives the shared datapath (one unified memory port, one ALU, register file, and the PC/IR/MDR/ALUOut registers) through fetch, decode, execute, memory and writeback steps for each instruction. It waits on a memory-ready handshake and reports retirement and illegal opcodes. It replaces the combinational main controller used by the single-cycle core; the existing ALU controller still decodes funct3/funct7 from the ALUOp produced here.

## Interface
Parameters: none (all encodings are fixed in the shared package).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  leave IDLE and begin fetching at the current PC
- opCode  in  7  IR[6:0], valid from DECODE onward
- memReady  in  1  memory completed the current request this cycle
- pcWrite  out  1  load PC unconditionally
- pcWriteCond  out  1  load PC if ALU zero (beq)
- irWrite  out  1  load IR from memory read data
- iorD  out  1  memory address: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request (data = rs2 register)
- regWrite  out  1  register file write enable
- regSrc  out  2  rd data: 0=ALUOut, 1=MDR, 2=PC (already PC+4)
- ALUSrcA  out  2  0=PC, 1=rs1 register, 2=oldPC (PC of current instruction)
- ALUSrcB  out  2  0=rs2 register, 1=constant 4, 2=immediate
- ALUOp  out  2  00=add, 01=sub, 10=R-type funct, 11=I-type funct
- PCSource  out  1  0=ALU result (combinational), 1=ALUOut register
- instRetired  out  1  one-cycle pulse on the final cycle of each instruction
- illegalInst  out  1  high while in TRAP
- state  out  4  current state, for debug and bench

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, TRAP.
- Every output is 0 unless listed for the current state.
- Outputs are Moore, except pcWrite/irWrite in FETCH and instRetired in MEM_WR, which are qualified by memReady.
- IDLE:
  - Go to FETCH when start=1; otherwise stay.
- FETCH:
  - memRead=1, iorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00.
  - Stay while memReady=0.
  - When memReady=1: irWrite=1, pcWrite=1, PCSource=0, go to DECODE.
- DECODE:
  - ALUSrcA=2, ALUSrcB=2, ALUOp=00, which leaves the branch/jal target in ALUOut.
  - Dispatch on opCode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - anything else → TRAP
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=2, ALUOp=00.
  - Go to MEM_RD if opCode[5]=0, else MEM_WR.
- MEM_RD:
  - memRead=1, iorD=1.
  - Wait for memReady, then go to MEM_WB.
- MEM_WB:
  - regWrite=1, regSrc=1, instRetired=1, go to FETCH.
- MEM_WR:
  - memWrite=1, iorD=1.
  - Wait for memReady; on memReady, instRetired=1 and go to FETCH.
- EXEC_R:
  - ALUSrcA=1, ALUSrcB=0, ALUOp=10, go to ALU_WB.
- EXEC_I:
  - ALUSrcA=1, ALUSrcB=2, ALUOp=11, go to ALU_WB.
- ALU_WB:
  - regWrite=1, regSrc=0, instRetired=1, go to FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=0, ALUOp=01, pcWriteCond=1, PCSource=1, instRetired=1, go to FETCH.
- JAL:
  - regWrite=1, regSrc=2, pcWrite=1, PCSource=1, instRetired=1, go to FETCH.
  - The register write samples the old PC value (PC+4) on the same edge that PC loads.
- JALR:
  - ALUSrcA=1, ALUSrcB=2, ALUOp=00, regWrite=1, regSrc=2, pcWrite=1, PCSource=0, instRetired=1, go to FETCH.
  - The datapath clears bit 0 of the target.
- TRAP:
  - illegalInst=1; stays in TRAP until reset.
- memReady outside FETCH, MEM_RD and MEM_WR is ignored.
- start outside IDLE is ignored.

## Timing
- Reset:
  - reset=1 at an edge puts the FSM in IDLE on that edge, from any state, including mid-wait.
  - All outputs are 0 during IDLE; a pending memory request is dropped.
- Latency with zero-wait memory (memReady high in the request cycle):
  - load 5 cycles; R/I-type 4; store 4; branch 3; jal 3; jalr 3.
- Each memory wait cycle adds exactly one cycle.
- The request (memRead/memWrite, iorD) stays stable until the memReady cycle inclusive.
- start=1 in IDLE puts the FSM in FETCH on the next edge.
- There is exactly one instRetired pulse per non-trapping instruction.

## Structure
- Shared package `multicycle_pkg` holds:
  - state enum (4-bit);
  - opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR);
  - select encodings for ALUSrcA, ALUSrcB, regSrc, ALUOp.
- One sub-module, `opcode_class_decoder`: combinational mapping of opCode to the DECODE next state, and the illegal flag.

## Test plan
- Reset then start=1, memReady tied 1, R-type add (opCode 0110011) → states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; regWrite=1 with regSrc=0 only in ALU_WB; one instRetired.
- Load with memReady low for 3 cycles in MEM_RD → MEM_RD held 4 cycles with memRead=1, iorD=1 stable; then MEM_WB regWrite=1, regSrc=1; 8 cycles total.
- beq (1100011) → BRANCH with ALUOp=01, pcWriteCond=1, PCSource=1; jal (1101111) → JAL with pcWrite=1, regSrc=2; each takes 3 cycles.
- Illegal opCode 1111111 → TRAP after DECODE; illegalInst=1 for 10 cycles with no write or retire; reset returns the FSM to IDLE.
- reset asserted mid MEM_WR wait → next cycle IDLE, memWrite=0; start ignored while not in IDLE.
